// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file with load scoreboard.
//
// Selects the write-back value from the MEM/WB register (load data or ALU
// result), writes it into a 2**ADDR_W entry register file, and serves two
// combinational ID-stage read ports with optional same-cycle bypass. A
// per-register pending bit tracks loads in flight so that ID can stall on
// a read of a register whose load has not yet retired.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   RegWrite_i, MemToReg_i  write-back enable and data select
//   RDaddr_i                write-back destination
//   RDData_i, ALUResult_i   load data / ALU result candidates
//   RSaddr_i, RTaddr_i      read port addresses
//   RSdata_o, RTdata_o      read port data
//   PendSet_i, PendAddr_i   mark a load destination pending
//   RSpend_o, RTpend_o      read address is pending
//   Stall_o                 either read port is pending
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              RegWrite_i,
   input  logic              MemToReg_i,
   input  logic [ADDR_W-1:0] RDaddr_i,
   input  logic [DATA_W-1:0] RDData_i,
   input  logic [DATA_W-1:0] ALUResult_i,
   input  logic [ADDR_W-1:0] RSaddr_i,
   input  logic [ADDR_W-1:0] RTaddr_i,
   output logic [DATA_W-1:0] RSdata_o,
   output logic [DATA_W-1:0] RTdata_o,
   input  logic              PendSet_i,
   input  logic [ADDR_W-1:0] PendAddr_i,
   output logic              RSpend_o,
   output logic              RTpend_o,
   output logic              Stall_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_nxt;
   logic [DATA_W-1:0] wdata;
   logic              load_retire;
   logic              rs_hit;
   logic              rt_hit;

   assign wdata       = MemToReg_i ? RDData_i : ALUResult_i;
   assign load_retire = RegWrite_i & MemToReg_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (RegWrite_i && (RDaddr_i != '0)) begin
         regs[RDaddr_i] <= wdata;
      end
   end

   // Set is applied after clear so a new load to the same register
   // supersedes the one retiring this cycle. Bit 0 is forced low last,
   // which also discards a set aimed at register 0.
   always_comb begin
      pend_nxt = pend;
      if (load_retire) begin
         pend_nxt[RDaddr_i] = 1'b0;
      end
      if (PendSet_i) begin
         pend_nxt[PendAddr_i] = 1'b1;
      end
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   assign rs_hit = BYPASS && RegWrite_i && (RDaddr_i == RSaddr_i);
   assign rt_hit = BYPASS && RegWrite_i && (RDaddr_i == RTaddr_i);

   // Outputs are gated by reset so that a live bypass path cannot leak
   // write-back data while the block is held in reset.
   always_comb begin
      RSdata_o = '0;
      RTdata_o = '0;
      RSpend_o = 1'b0;
      RTpend_o = 1'b0;
      if (rst_n_i) begin
         if (RSaddr_i != '0) begin
            RSdata_o = rs_hit ? wdata : regs[RSaddr_i];
         end
         if (RTaddr_i != '0) begin
            RTdata_o = rt_hit ? wdata : regs[RTaddr_i];
         end
         // A retiring load is bypassed to the reader, so it does not stall.
         RSpend_o = pend[RSaddr_i] & ~(rs_hit & MemToReg_i);
         RTpend_o = pend[RTaddr_i] & ~(rt_hit & MemToReg_i);
      end
      Stall_o = RSpend_o | RTpend_o;
   end

endmodule
